// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the request slot record used by the LSU bridge.
package ahb_pkg;

   localparam int AHB_W = 32;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      SIZE_B  = 3'b000,
      SIZE_HW = 3'b001,
      SIZE_W  = 3'b010
   } hsize_e;

   typedef enum logic [2:0] {
      BURST_SINGLE = 3'b000
   } hburst_e;

   typedef enum logic {
      RESP_OKAY  = 1'b0,
      RESP_ERROR = 1'b1
   } hresp_e;

   // LSU size code that has no AHB equivalent; answered locally with an error.
   localparam logic [1:0] REQ_SIZE_BAD = 2'd3;

   typedef struct packed {
      logic [AHB_W-1:0] addr;
      logic             write;
      logic [1:0]       size;
      logic [AHB_W-1:0] wdata;
      logic             valid;
   } slot_t;

endpackage

// File: rtl/ahb_lsu_master.sv
// LSU-to-AHB-lite bridge: pipelined single transfers through an address slot (A)
// and a data slot (D), with wait-state, two-cycle ERROR and illegal-size handling.
module ahb_lsu_master
   import ahb_pkg::*;
#(
   parameter int         AHB_BUS_WIDTH = AHB_W,
   parameter logic [3:0] HPROT_VAL     = 4'b0011
) (
   input  logic                     HCLK,
   input  logic                     HRST,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [AHB_BUS_WIDTH-1:0] req_addr,
   input  logic                     req_write,
   input  logic [1:0]               req_size,
   input  logic [AHB_BUS_WIDTH-1:0] req_wdata,
   output logic                     rsp_valid,
   output logic [AHB_BUS_WIDTH-1:0] rsp_rdata,
   output logic                     rsp_err,
   output logic [AHB_BUS_WIDTH-1:0] HADDR_o,
   output logic [1:0]               HTRANS_o,
   output logic [2:0]               HSIZE_o,
   output logic [2:0]               HBURST_o,
   output logic [3:0]               HPROT_o,
   output logic                     HWRITE_o,
   output logic [AHB_BUS_WIDTH-1:0] HWDATA_o,
   input  logic [AHB_BUS_WIDTH-1:0] HRDATA_i,
   input  logic                     HREADY_i,
   input  logic                     HRESP_i
);

   slot_t r_a, r_d;
   slot_t w_a_next, w_d_next, w_req;
   logic  r_run;
   logic  r_err_hold, w_err_hold_next;
   logic  r_cancel, w_cancel_next;
   logic  r_rsp_valid, w_rsp_valid_next;
   logic  r_rsp_err, w_rsp_err_next;
   logic  [AHB_BUS_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_next;

   logic  w_illegal, w_d_done, w_d_err, w_err_first, w_cancel_emit;
   logic  w_accept, w_accept_bus, w_accept_bad;
   logic  w_unused;

   assign w_illegal     = (req_size == REQ_SIZE_BAD);
   assign w_d_done      = r_d.valid && HREADY_i;
   assign w_d_err       = (HRESP_i == RESP_ERROR);
   assign w_err_first   = r_d.valid && !HREADY_i && w_d_err;
   // D has already retired its error; the only thing left is the cancelled-A report.
   assign w_cancel_emit = r_err_hold && !r_d.valid;

   assign req_ready    = r_run && !r_err_hold && (!r_a.valid || HREADY_i)
                         && !(w_illegal && w_d_done);
   assign w_accept     = req_valid && req_ready;
   assign w_accept_bus = w_accept && !w_illegal;
   assign w_accept_bad = w_accept && w_illegal;

   always_comb begin
      w_a_next         = r_a;
      w_d_next         = r_d;
      w_err_hold_next  = r_err_hold;
      w_cancel_next    = r_cancel;
      w_rsp_valid_next = 1'b0;
      w_rsp_err_next   = 1'b0;
      w_rsp_rdata_next = '0;

      w_req.addr  = req_addr;
      w_req.write = req_write;
      w_req.size  = req_size;
      w_req.wdata = req_wdata;
      w_req.valid = 1'b1;

      if (HREADY_i) begin
         if (r_a.valid) w_d_next = r_a;
         else           w_d_next.valid = 1'b0;
         w_a_next.valid = 1'b0;
      end

      if (w_err_first) begin
         w_a_next.valid  = 1'b0;
         w_err_hold_next = 1'b1;
         w_cancel_next   = r_cancel || r_a.valid || w_accept_bus;
      end else if (w_accept_bus) begin
         w_a_next = w_req;
      end

      if (w_d_done) begin
         w_rsp_valid_next = 1'b1;
         w_rsp_err_next   = w_d_err;
         w_rsp_rdata_next = (r_d.write || w_d_err) ? '0 : HRDATA_i;
         // Stay blocked one more cycle only if a cancelled entry still owes a response.
         if (w_d_err) w_err_hold_next = r_cancel;
      end else if (w_cancel_emit) begin
         w_rsp_valid_next = 1'b1;
         w_rsp_err_next   = 1'b1;
         w_cancel_next    = 1'b0;
         w_err_hold_next  = 1'b0;
      end else if (w_accept_bad) begin
         w_rsp_valid_next = 1'b1;
         w_rsp_err_next   = 1'b1;
      end
   end

   always_ff @(posedge HCLK or posedge HRST) begin
      if (HRST) begin
         r_a         <= '0;
         r_d         <= '0;
         r_run       <= 1'b0;
         r_err_hold  <= 1'b0;
         r_cancel    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_a         <= w_a_next;
         r_d         <= w_d_next;
         r_run       <= 1'b1;
         r_err_hold  <= w_err_hold_next;
         r_cancel    <= w_cancel_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_rsp_err   <= w_rsp_err_next;
         r_rsp_rdata <= w_rsp_rdata_next;
      end
   end

   assign HTRANS_o  = r_a.valid ? TRANS_NONSEQ : TRANS_IDLE;
   assign HADDR_o   = r_a.addr;
   assign HSIZE_o   = {1'b0, r_a.size};
   assign HWRITE_o  = r_a.write;
   assign HWDATA_o  = r_d.wdata;
   assign HBURST_o  = BURST_SINGLE;
   assign HPROT_o   = HPROT_VAL;

   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

   assign w_unused  = ^{r_d.addr, r_d.size};

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Randomized plus directed bench for ahb_lsu_master against a transaction-queue model.
module tb_ahb_lsu_master;

   logic        HCLK = 1'b0;
   logic        HRST;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR_o, HWDATA_o, HRDATA_i;
   logic [1:0]  HTRANS_o;
   logic [2:0]  HSIZE_o, HBURST_o;
   logic [3:0]  HPROT_o;
   logic        HWRITE_o, HREADY_i, HRESP_i;

   ahb_lsu_master dut (
      .HCLK(HCLK), .HRST(HRST),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HADDR_o(HADDR_o), .HTRANS_o(HTRANS_o), .HSIZE_o(HSIZE_o), .HBURST_o(HBURST_o),
      .HPROT_o(HPROT_o), .HWRITE_o(HWRITE_o), .HWDATA_o(HWDATA_o),
      .HRDATA_i(HRDATA_i), .HREADY_i(HREADY_i), .HRESP_i(HRESP_i)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [1:0]  size;
      logic [31:0] wdata;
   } txn_t;

   // Model: ordered list of requests owned by the bus; head may be in its data phase.
   txn_t        outs[$];
   bit          head_dp;
   bit          m_err_wait2, m_cancel, m_cancel_due;
   bit          e_rsp_valid, e_rsp_err;
   logic [31:0] e_rsp_rdata;

   int n_vec = 0;
   int n_miscmp = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      outs.delete();
      head_dp      = 0;
      m_err_wait2  = 0;
      m_cancel     = 0;
      m_cancel_due = 0;
      e_rsp_valid  = 0;
      e_rsp_err    = 0;
      e_rsp_rdata  = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_htrans"}, 32'(HTRANS_o), 32'd0);
      chk({tag, "_haddr"}, HADDR_o, 32'd0);
      chk({tag, "_hsize"}, 32'(HSIZE_o), 32'd0);
      chk({tag, "_hwrite"}, 32'(HWRITE_o), 32'd0);
      chk({tag, "_hwdata"}, HWDATA_o, 32'd0);
      chk({tag, "_hburst"}, 32'(HBURST_o), 32'd0);
      chk({tag, "_hprot"}, 32'(HPROT_o), 32'd3);
      chk({tag, "_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
   endtask

   // One bus cycle: drive, compare against the model, then advance the model past the edge.
   task automatic cycle(input bit v, input logic [31:0] a, input bit w, input logic [1:0] sz,
                        input logic [31:0] wd, input bit hr, input bit hresp,
                        input logic [31:0] hrd, output bit fired);
      int   ai;
      bit   has_a, d_done, err_hold, exp_ready, nv, ne;
      logic [31:0] nr;
      txn_t t;
      @(negedge HCLK);
      req_valid = v; req_addr = a; req_write = w; req_size = sz; req_wdata = wd;
      HREADY_i = hr; HRESP_i = hresp; HRDATA_i = hrd;
      #1;
      ai        = head_dp ? 1 : 0;
      has_a     = outs.size() > ai;
      d_done    = head_dp && hr;
      err_hold  = m_err_wait2 || m_cancel_due;
      exp_ready = !err_hold && (!has_a || hr) && !(sz == 2'd3 && d_done);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("htrans", 32'(HTRANS_o), has_a ? 32'd2 : 32'd0);
      if (has_a) begin
         t = outs[ai];
         chk("haddr", HADDR_o, t.addr);
         chk("hsize", 32'(HSIZE_o), 32'(t.size));
         chk("hwrite", 32'(HWRITE_o), 32'(t.write));
      end
      if (head_dp && outs[0].write) chk("hwdata", HWDATA_o, outs[0].wdata);
      chk("hburst", 32'(HBURST_o), 32'd0);
      chk("hprot", 32'(HPROT_o), 32'd3);
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      if (e_rsp_valid) begin
         chk("rsp_err", 32'(rsp_err), 32'(e_rsp_err));
         chk("rsp_rdata", rsp_rdata, e_rsp_rdata);
      end

      fired = v && exp_ready;
      nv = 0; ne = 0; nr = 0;
      if (d_done) begin
         nv = 1;
         ne = hresp;
         nr = (hresp || outs[0].write) ? 32'd0 : hrd;
         void'(outs.pop_front());
         head_dp = 0;
         if (hresp) begin
            m_err_wait2  = 0;
            m_cancel_due = m_cancel;
            m_cancel     = 0;
         end
      end else if (m_cancel_due) begin
         nv = 1; ne = 1; m_cancel_due = 0;
      end else if (fired && sz == 2'd3) begin
         nv = 1; ne = 1;
      end
      if (head_dp && !hr && hresp) begin
         m_err_wait2 = 1;
         if (outs.size() > 1) begin
            void'(outs.pop_back());
            m_cancel = 1;
         end
         if (fired && sz != 2'd3) m_cancel = 1;
      end else begin
         if (hr && outs.size() > 0) head_dp = 1;
         if (fired && sz != 2'd3) outs.push_back('{a, w, sz, wd});
      end
      e_rsp_valid = nv; e_rsp_err = ne; e_rsp_rdata = nr;
   endtask

   task automatic idle(input bit hr, input bit hresp, input logic [31:0] hrd);
      bit f;
      cycle(0, 32'd0, 0, 2'd0, 32'd0, hr, hresp, hrd, f);
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit f;
      bit p_v, hr, hresp, v;
      logic [31:0] p_a, p_wd;
      logic [1:0]  p_sz;
      bit          p_w;

      HRST = 1; req_valid = 0; req_addr = 0; req_write = 0; req_size = 0; req_wdata = 0;
      HRDATA_i = 0; HREADY_i = 1; HRESP_i = 0;
      model_reset();
      repeat (2) @(negedge HCLK);
      #1;
      chk_reset_vals("rst");
      HRST = 0;
      #1;
      chk("rst_release_ready", 32'(req_ready), 32'd0);

      // Single word write
      cycle(1, 32'h10, 1, 2'd2, 32'hDEADBEEF, 1, 0, 32'd0, f);
      chk("t1_ready", 32'(req_ready), 32'd1);
      idle(1, 0, 32'h0);
      chk("t1_htrans", 32'(HTRANS_o), 32'd2);
      chk("t1_haddr", HADDR_o, 32'h10);
      idle(1, 0, 32'h0);
      chk("t1_hwdata", HWDATA_o, 32'hDEADBEEF);
      idle(1, 0, 32'h0);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_err", 32'(rsp_err), 32'd0);
      chk("t1_rsp_rdata", rsp_rdata, 32'd0);
      idle(1, 0, 32'h0);

      // Back-to-back reads, two wait states on 0x4 while 0x8 sits in the address phase
      cycle(1, 32'h0, 0, 2'd2, 32'd0, 1, 0, 32'd0, f);
      cycle(1, 32'h4, 0, 2'd2, 32'd0, 1, 0, 32'd0, f);
      chk("t2_htrans0", 32'(HTRANS_o), 32'd2);
      chk("t2_haddr0", HADDR_o, 32'h0);
      cycle(1, 32'h8, 0, 2'd2, 32'd0, 1, 0, 32'h0A0A0A0A, f);
      chk("t2_htrans1", 32'(HTRANS_o), 32'd2);
      chk("t2_haddr1", HADDR_o, 32'h4);
      idle(0, 0, 32'h0BAD0BAD);
      chk("t2_htrans2", 32'(HTRANS_o), 32'd2);
      chk("t3_haddr_w1", HADDR_o, 32'h8);
      chk("t3_ready_w1", 32'(req_ready), 32'd0);
      chk("t2_rdata0", rsp_rdata, 32'h0A0A0A0A);
      idle(0, 0, 32'h0BAD0BAD);
      chk("t3_haddr_w2", HADDR_o, 32'h8);
      chk("t3_ready_w2", 32'(req_ready), 32'd0);
      chk("t3_no_rsp", 32'(rsp_valid), 32'd0);
      idle(1, 0, 32'h44444444);
      idle(1, 0, 32'h88888888);
      chk("t2_rdata1", rsp_rdata, 32'h44444444);
      idle(1, 0, 32'h0);
      chk("t2_rdata2", rsp_rdata, 32'h88888888);
      idle(1, 0, 32'h0);

      // ERROR on a write with a read queued behind it
      cycle(1, 32'h10000000, 1, 2'd2, 32'h12345678, 1, 0, 32'd0, f);
      cycle(1, 32'h20, 0, 2'd2, 32'd0, 1, 0, 32'd0, f);
      idle(0, 1, 32'h0);
      chk("t4_haddr_pending", HADDR_o, 32'h20);
      idle(1, 1, 32'h0);
      chk("t4_htrans_idle", 32'(HTRANS_o), 32'd0);
      chk("t4_ready_held", 32'(req_ready), 32'd0);
      idle(1, 0, 32'h0);
      chk("t4_rsp1_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rsp1_err", 32'(rsp_err), 32'd1);
      chk("t4_rsp1_rdata", rsp_rdata, 32'd0);
      chk("t4_htrans_still_idle", 32'(HTRANS_o), 32'd0);
      idle(1, 0, 32'h0);
      chk("t4_rsp2_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rsp2_err", 32'(rsp_err), 32'd1);
      chk("t4_ready_back", 32'(req_ready), 32'd1);
      idle(1, 0, 32'h0);
      chk("t4_rsp_done", 32'(rsp_valid), 32'd0);

      // Illegal size
      cycle(1, 32'h4, 0, 2'd3, 32'd0, 1, 0, 32'd0, f);
      chk("t5_ready", 32'(req_ready), 32'd1);
      idle(1, 0, 32'h0);
      chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t5_rsp_err", 32'(rsp_err), 32'd1);
      chk("t5_no_bus", 32'(HTRANS_o), 32'd0);
      idle(1, 0, 32'h0);

      // Reset during a data phase
      cycle(1, 32'h40, 0, 2'd2, 32'd0, 1, 0, 32'd0, f);
      idle(1, 0, 32'h0);
      @(negedge HCLK);
      req_valid = 0; HREADY_i = 1; HRESP_i = 0;
      HRST = 1;
      #1;
      chk_reset_vals("rst_mid");
      model_reset();
      repeat (2) @(negedge HCLK);
      HRST = 0;
      #1;
      chk("rst_mid_release_ready", 32'(req_ready), 32'd0);
      repeat (4) idle(1, 0, 32'h5A5A5A5A);

      // Randomized traffic with wait states and occasional two-cycle errors
      p_v = 0; p_a = 0; p_w = 0; p_sz = 0; p_wd = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!p_v && $urandom_range(0, 3) != 0) begin
            p_v  = 1;
            p_a  = $urandom;
            if ($urandom_range(0, 1) == 1) p_a[1:0] = 2'b00;
            p_w  = 1'($urandom_range(0, 1));
            p_sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            p_wd = $urandom;
         end
         v     = p_v;
         hresp = 0;
         hr    = ($urandom_range(0, 3) != 0);
         if (m_err_wait2) begin
            hr = 1; hresp = 1;
         end else if (head_dp && $urandom_range(0, 11) == 0) begin
            hr = 0; hresp = 1; v = 0;
         end
         cycle(v, p_a, p_w, p_sz, p_wd, hr, hresp, $urandom, f);
         if (f) p_v = 0;
      end
      repeat (4) idle(1, 0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
